// File: rtl/multicycle_controller.sv
// Multicycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB for a single-ALU
// datapath; ports: clk, rst_n, op, funct, zero, mem_ready -> ALU/mux/strobe controls, state.
module multicycle_controller #(
  parameter logic [3:0] NOR_CODE = 4'b1100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [3:0] alu_control,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,
    MEMRD  = 4'd3,  MEMWB  = 4'd4,  MEMWR  = 4'd5,
    EXEC   = 4'd6,  ALUWB  = 4'd7,  BRANCH = 4'd8,
    ADDIEX = 4'd9,  ADDIWB = 4'd10, JUMP   = 4'd11
  } state_e;

  localparam logic [3:0] ALU_ADD = 4'b0010;

  state_e state_q, state_d;
  logic   is_sw_q, is_sw_d;
  logic   funct_ok;

  always_comb begin
    funct_ok = 1'b0;
    unique case (funct)
      6'b100000, 6'b100010, 6'b100100,
      6'b100101, 6'b101010, 6'b100111: funct_ok = 1'b1;
      default: funct_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      is_sw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      is_sw_q <= is_sw_d;
    end
  end

  // lw/sw choice is captured in DECODE so MEMADR need not re-read op
  always_comb begin
    state_d = FETCH;
    is_sw_d = is_sw_q;
    unique case (state_q)
      FETCH:  state_d = mem_ready ? DECODE : FETCH;
      DECODE: begin
        is_sw_d = (op == 6'b101011);
        unique case (op)
          6'b000000: state_d = funct_ok ? EXEC : FETCH;
          6'b100011,
          6'b101011: state_d = MEMADR;
          6'b000100: state_d = BRANCH;
          6'b001000: state_d = ADDIEX;
          6'b000010: state_d = JUMP;
          default:   state_d = FETCH;
        endcase
      end
      MEMADR: state_d = is_sw_q ? MEMWR : MEMRD;
      MEMRD:  state_d = mem_ready ? MEMWB : MEMRD;
      MEMWR:  state_d = mem_ready ? FETCH : MEMWR;
      EXEC:   state_d = ALUWB;
      ADDIEX: state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    alu_control = ALU_ADD;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    pc_src      = 2'b00;
    pc_en       = 1'b0;
    iord        = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    illegal_op  = 1'b0;
    unique case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        unique case (op)
          6'b000000: illegal_op = !funct_ok;
          6'b100011, 6'b101011, 6'b000100,
          6'b001000, 6'b000010: illegal_op = 1'b0;
          default: illegal_op = 1'b1;
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        unique case (funct)
          6'b100010: alu_control = 4'b0110;
          6'b100100: alu_control = 4'b0000;
          6'b100101: alu_control = 4'b0001;
          6'b101010: alu_control = 4'b0111;
          6'b100111: alu_control = NOR_CODE;
          default:   alu_control = ALU_ADD;
        endcase
      end
      ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = 4'b0110;
        pc_src      = 2'b01;
        pc_en       = zero;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      ADDIWB: reg_write = 1'b1;
      JUMP: begin
        pc_src = 2'b10;
        pc_en  = 1'b1;
      end
      default: ;
    endcase
    // state already reads FETCH during reset; keep its strobes quiet too
    if (!rst_n) begin
      pc_en      = 1'b0;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      illegal_op = 1'b0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: random instruction stream with random stalls,
// each cycle checked against a per-instruction expected-cycle script.
module tb_multicycle_controller;

  logic       clk = 0;
  logic       rst_n = 0;
  logic [5:0] op = 0, funct = 0;
  logic       zero = 0, mem_ready = 1;
  logic [3:0] alu_control, state;
  logic       alu_src_a, pc_en, iord, mem_read, mem_write;
  logic       ir_write, reg_write, reg_dst, mem_to_reg, illegal_op;
  logic [1:0] alu_src_b, pc_src;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct),
    .zero(zero), .mem_ready(mem_ready),
    .alu_control(alu_control), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_src(pc_src), .pc_en(pc_en),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic [5:0] op, fn;
    logic       mr, z;
    logic [3:0] alu;
    logic       sa;
    logic [1:0] sb, ps;
    logic       pe, iord, mrd, mwr, irw, rw, rd, m2r, ill;
  } cyc_t;

  cyc_t q[$];
  int n_cmp = 0, n_bad = 0, cyc = 0;
  logic [5:0] cur_op, cur_fn;

  logic [5:0] r_fn  [6] = '{6'b100000, 6'b100010, 6'b100100,
                            6'b100101, 6'b101010, 6'b100111};
  logic [3:0] r_alu [6] = '{4'b0010, 4'b0110, 4'b0000,
                            4'b0001, 4'b0111, 4'b1100};
  logic [5:0] ops   [6] = '{6'b000000, 6'b100011, 6'b101011,
                            6'b000100, 6'b001000, 6'b000010};

  task automatic chk(string tag, logic [15:0] got, logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic int fn_idx(logic [5:0] f);
    for (int i = 0; i < 6; i++) if (r_fn[i] == f) return i;
    return -1;
  endfunction

  function automatic bit op_known(logic [5:0] o);
    for (int i = 0; i < 6; i++) if (ops[i] == o) return 1;
    return 0;
  endfunction

  function automatic cyc_t blank(int st);
    cyc_t c;
    c = '0;
    c.st = st[3:0];
    c.op = cur_op;
    c.fn = cur_fn;
    c.mr = 1'($urandom);
    c.z = 1'($urandom);
    c.alu = 4'b0010;
    return c;
  endfunction

  // Expected cycle-by-cycle script for one instruction
  task automatic gen(logic [5:0] o, logic [5:0] f,
                     int fst, int mst, logic zb);
    cyc_t c;
    bit legal;
    cur_op = o;
    cur_fn = f;
    for (int i = 0; i <= fst; i++) begin
      c = blank(0);
      c.mrd = 1; c.sb = 2'b01;
      c.mr = (i == fst);
      c.irw = c.mr; c.pe = c.mr;
      q.push_back(c);
    end
    legal = op_known(o) && !(o == 0 && fn_idx(f) < 0);
    c = blank(1);
    c.sb = 2'b11; c.ill = !legal;
    q.push_back(c);
    if (!legal) return;
    if (o == 6'b000000) begin
      c = blank(6); c.sa = 1; c.alu = r_alu[fn_idx(f)];
      q.push_back(c);
      c = blank(7); c.rw = 1; c.rd = 1;
      q.push_back(c);
    end else if (o == 6'b100011 || o == 6'b101011) begin
      c = blank(2); c.sa = 1; c.sb = 2'b10;
      q.push_back(c);
      for (int i = 0; i <= mst; i++) begin
        c = blank(o == 6'b100011 ? 3 : 5);
        c.iord = 1;
        c.mr = (i == mst);
        if (o == 6'b100011) c.mrd = 1; else c.mwr = 1;
        q.push_back(c);
      end
      if (o == 6'b100011) begin
        c = blank(4); c.rw = 1; c.m2r = 1;
        q.push_back(c);
      end
    end else if (o == 6'b000100) begin
      c = blank(8); c.sa = 1; c.alu = 4'b0110; c.ps = 2'b01;
      c.z = zb; c.pe = zb;
      q.push_back(c);
    end else if (o == 6'b001000) begin
      c = blank(9); c.sa = 1; c.sb = 2'b10;
      q.push_back(c);
      c = blank(10); c.rw = 1;
      q.push_back(c);
    end else begin
      c = blank(11); c.ps = 2'b10; c.pe = 1;
      q.push_back(c);
    end
  endtask

  task automatic check_cycle(cyc_t c);
    chk("state", 16'(state), 16'(c.st));
    chk("alu", 16'(alu_control), 16'(c.alu));
    chk("strobe", 16'({pc_en, ir_write, mem_read, mem_write, reg_write, illegal_op}),
        16'({c.pe, c.irw, c.mrd, c.mwr, c.rw, c.ill}));
    chk("mux", 16'({alu_src_a, alu_src_b, pc_src, iord, reg_dst, mem_to_reg}),
        16'({c.sa, c.sb, c.ps, c.iord, c.rd, c.m2r}));
  endtask

  task automatic run();
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      @(negedge clk);
      rst_n = 1;
      op = c.op; funct = c.fn; mem_ready = c.mr; zero = c.z;
      #1;
      cyc++;
      check_cycle(c);
    end
  endtask

  task automatic check_reset();
    chk("rst_state", 16'(state), 16'd0);
    chk("rst_strobe", 16'({pc_en, ir_write, mem_read, mem_write, reg_write, illegal_op}),
        16'd0);
  endtask

  initial begin
    logic [5:0] o, f;
    int k;
    rst_n = 0; mem_ready = 1; op = 6'b000000; funct = 6'b100000;
    repeat (3) begin
      @(negedge clk); #1;
      check_reset();
    end
    gen(6'b000000, 6'b100010, 0, 0, 0);
    gen(6'b100011, 6'h15, 0, 2, 0);
    gen(6'b000100, 6'h00, 0, 0, 1);
    gen(6'b000100, 6'h00, 0, 0, 0);
    gen(6'b111111, 6'h20, 0, 0, 0);
    gen(6'b000000, 6'b000000, 0, 0, 0);
    gen(6'b101011, 6'h01, 1, 1, 0);
    gen(6'b001000, 6'h2a, 0, 0, 0);
    gen(6'b000010, 6'h3f, 2, 0, 0);
    run();
    for (int n = 0; n < 80; n++) begin
      k = $urandom_range(0, 7);
      f = 6'($urandom);
      if (k == 0) f = r_fn[$urandom_range(0, 5)];
      if (k <= 5) o = ops[k];
      else if (k == 6) begin
        o = 6'($urandom);
        while (op_known(o)) o = 6'($urandom);
      end else begin
        o = 0;
        while (fn_idx(f) >= 0) f = 6'($urandom);
      end
      gen(o, f, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom));
      run();
    end
    gen(6'b101011, 6'h00, 0, 3, 0);
    repeat (3) void'(q.pop_back());
    run();
    #2 rst_n = 0;
    #1 check_reset();
    @(posedge clk); #1;
    check_reset();
    @(negedge clk); #1;
    check_reset();
    gen(6'b000000, 6'b100111, 0, 0, 0);
    run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multicycle control FSM that drives the 4-bit ALU control code and datapath strobes, and consumes the ALU Zero flag. It sits between instruction memory/IR and the shared single-ALU datapath. It sequences each instruction through fetch, decode, execute, memory and writeback states, stalling on a memory ready handshake. It supports the R-type subset (add, sub, and, or, slt, nor) plus lw, sw, beq, addi and j.

## Interface
Parameters:
- NOR_CODE, 4'b1100, ALU control code emitted for R-type nor

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- op  in  6  IR[31:26], sampled in DECODE
- funct  in  6  IR[5:0], sampled in DECODE and EXEC
- zero  in  1  ALU Zero flag, same-cycle combinational
- mem_ready  in  1  memory completes current read/write this cycle
- alu_control  out  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, NOR_CODE NOR
- alu_src_a  out  1  0=PC, 1=reg A
- alu_src_b  out  2  00=reg B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- pc_src  out  2  00=ALU result, 01=ALUOut register, 10=jump target
- pc_en  out  1  PC load = pc_write OR (branch AND zero)
- iord  out  1  memory address: 0=PC, 1=ALUOut
- mem_read, mem_write, ir_write, reg_write  out  1 each  strobes
- reg_dst  out  1  0=rt, 1=rd
- mem_to_reg  out  1  0=ALUOut, 1=MDR
- illegal_op  out  1  one-cycle pulse on unsupported op/funct
- state  out  4  current state encoding, for debug

## Operation
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11. Codes 12–15 are unreachable and map to FETCH.
- Outputs are Moore-decoded from state, except the mem_ready-qualified strobes and pc_en. Any output not listed for a state is 0. alu_control defaults to ADD.
- FETCH: mem_read=1, iord=0, src_a=0, src_b=01, ADD, pc_src=00.
  - ir_write=pc_en=mem_ready.
  - Stay while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: src_a=0, src_b=11, ADD (precomputes branch target).
  - Next state by op: 000000→EXEC, 100011/101011→MEMADR, 000100→BRANCH, 001000→ADDIEX, 000010→JUMP.
  - If op=000000 with funct outside {100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, 100111 nor}: illegal_op=1, next FETCH.
  - Any other op: illegal_op=1, next FETCH.
- MEMADR: src_a=1, src_b=10, ADD. Next MEMRD for lw, MEMWR for sw.
- MEMRD: mem_read=1, iord=1. Stall until mem_ready, then MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1. Next FETCH.
- MEMWR: mem_write=1, iord=1. Stall until mem_ready, then FETCH.
- EXEC: src_a=1, src_b=00, alu_control from funct (add→0010, sub→0110, and→0000, or→0001, slt→0111, nor→NOR_CODE). Next ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. Next FETCH.
- BRANCH: src_a=1, src_b=00, SUB, pc_src=01, pc_en=zero. Next FETCH.
- ADDIEX: src_a=1, src_b=10, ADD. Next ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. Next FETCH.
- JUMP: pc_src=10, pc_en=1. Next FETCH.

## Timing
- Reset: rst_n low forces state=FETCH immediately (asynchronous). While rst_n is low, all strobes (pc_en, ir_write, mem_read, mem_write, reg_write, illegal_op) are 0. After release, FETCH outputs apply from the first clock edge.
- Latency with mem_ready held at 1 (cycles, FETCH through return to FETCH): R-type 4, lw 5, sw 4, beq 3, addi 4, j 3, illegal 2.
- Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle. No strobe repeats while stalled: ir_write and pc_en stay 0 until the completing cycle.
- mem_write is asserted for every cycle in MEMWR, and the write is committed only on the cycle with mem_ready=1.
- zero is used combinationally only in BRANCH. It is ignored in every other state.
- Reset asserted mid-instruction aborts it. No reg_write or mem_write is issued after rst_n falls.

## Test plan
- Reset: hold rst_n=0 three cycles with mem_ready=1 → state=0, all strobes 0. Release → first cycle shows mem_read=1, ir_write=1, pc_en=1, alu_control=0010.
- R-type sub (op=0, funct=100010), mem_ready=1 → states 0,1,6,7,0. EXEC alu_control=0110. ALUWB reg_write=1, reg_dst=1.
- lw with mem_ready low 2 cycles in MEMRD → states 0,1,2,3,3,3,4,0. MEMWB reg_write=1, mem_to_reg=1.
- beq twice: zero=1 → pc_en=1, pc_src=01 in BRANCH. zero=0 → pc_en=0. Both take 3 cycles back to FETCH.
- Illegal op=111111, then op=0 with funct=000000 → each gives illegal_op pulse of exactly 1 cycle in DECODE, followed by FETCH, with no reg_write.
- sw with rst_n pulled low during MEMWR (mem_ready=0) → state=0 asynchronously, mem_write drops that cycle, and no write completes.
